ddr_wr_data_sched: RTL and testbench
====================================

// Module: ddr_wr_data_sched
// PURPOSE
//  Write-data scheduler upstream of the DQ/DQS write driver. Buffers host write
//  bursts in an in-order FIFO and matches each to a WR command on the bus.
//  Launches the data to the driver (wr_rdy pulse plus payload) exactly
//  cwl - wr_pre clocks after the WR command, so the driver's preamble and burst
//  land on CAS write latency.
// PARAMETERS
//  DATA_W   64  burst payload width; beat 0 = [7:0], 8 beats of x8
//  DEPTH    8   write-data FIFO entries (power of 2)
//  CWL_MAX  24  largest supported CAS write latency, in clocks; sizes launch shift reg
// PORTS
//  CK_t           in   1       clock, all state on posedge
//  reset          in   1       asynchronous, active-high; clears all state
//  host_wr_valid  in   1       host write payload valid
//  host_wr_ready  out  1       FIFO can accept (= count < DEPTH)
//  host_data      in   DATA_W  burst payload
//  host_bl        in   4       burst length in beats (8 or 4), stored per entry
//  wr_cmd_issued  in   1       1-clk pulse: WR command driven on the command bus
//  cwl            in   5       CAS write latency (static; mode register value)
//  wr_pre         in   2       write preamble clocks, 1 or 2 (static)
//  wr_rdy         out  1       1-clk launch pulse to the write driver
//  wr_data        out  DATA_W  launched payload, held until next launch
//  wr_bl          out  4       launched burst length, held until next launch
//  fifo_count     out  $clog2(DEPTH)+1  entries buffered
//  underflow      out  1       sticky: launch occurred with FIFO empty
//  cmd_collide    out  1       sticky: two commands mapped to the same launch slot
// BEHAVIOUR
//  Reset values: wr_rdy=0, wr_data=0, wr_bl=0, fifo_count=0, underflow=0,
//   cmd_collide=0, launch shift reg=0, FIFO pointers=0.
//  host_wr_ready is combinational (!full), so it reads 1 out of reset.
//  Reset mid-burst discards all buffered entries and pending launches.
//  FIFO: push on host_wr_valid && host_wr_ready, storing {host_bl, host_data}.
//   No push when full. Pointers wrap modulo DEPTH.
//  Launch delay: D = cwl - wr_pre, clamped to the range 1..CWL_MAX.
//  Launch shift reg L[CWL_MAX-1:0]:
//   - Every clock: L <= L >> 1.
//   - On wr_cmd_issued at cycle T: set bit D-1 in the shifted value.
//   - If that bit is already 1: keep it 1 and set cmd_collide.
//  fire = L[0]. When fire is 1 at the edge ending cycle T+D-1, the following
//   happens together:
//   - FIFO non-empty: pop the head; wr_data/wr_bl <= head; wr_rdy=1 in cycle T+D.
//   - FIFO empty: wr_rdy stays 0, wr_data/wr_bl hold, underflow <= 1.
//  wr_rdy is never high two consecutive clocks unless two commands were 1 clock apart.
//  Simultaneous push and pop: both occur; count unchanged. Pop at full frees a
//   slot, so host_wr_ready rises the next cycle.
//  Ordering: the Nth launch always consumes the Nth pushed entry. No reordering,
//   no per-command tagging.
//  cwl and wr_pre are sampled at each command. Changing them with launches
//   pending is a bench error; the design behaves as the shift contents dictate.
//  underflow and cmd_collide clear only on reset.
// TESTING
//  1. Reset, cwl=9, wr_pre=1; push 0x0807060504030201 (bl=8); wr_cmd_issued
//     at T -> wr_rdy high only at T+8, wr_data=0x0807060504030201, wr_bl=8,
//     fifo_count 1->0.
//  2. wr_pre=2, cwl=9, 3 entries A,B,C; cmds at T, T+4, T+8 -> wr_rdy at
//     T+7, T+11, T+15 with A,B,C in order.
//  3. Push 8 entries, no cmds -> host_wr_ready=0, fifo_count=8; 9th valid is
//     not accepted; one launch -> ready=1 next clock; push+pop same clock keeps
//     count at 8.
//  4. cmd with FIFO empty, cwl=10, wr_pre=1 -> no wr_rdy at T+9, underflow=1,
//     wr_data holds its prior value.
//  5. Assert reset two clocks after a cmd, with 3 entries queued -> all outputs
//     0, no launch afterwards, fifo_count=0, host_wr_ready=1.
//  6. cwl=1, wr_pre=2 (D clamped to 1) -> wr_rdy at T+1. Also: cmd at T with
//     cwl=12, then cmd at T+1 with cwl=11 -> cmd_collide=1.

Source files
------------

// File: rtl/ddr_wr_data_sched.sv
// Write-data scheduler: in-order FIFO of host bursts, launched to the DQ/DQS
// driver cwl - wr_pre clocks after each WR command via a one-hot shift register.
module ddr_wr_data_sched #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CWL_MAX = 24
) (
    input  logic                     CK_t,
    input  logic                     reset,
    input  logic                     host_wr_valid,
    output logic                     host_wr_ready,
    input  logic [DATA_W-1:0]        host_data,
    input  logic [3:0]               host_bl,
    input  logic                     wr_cmd_issued,
    input  logic [4:0]               cwl,
    input  logic [1:0]               wr_pre,
    output logic                     wr_rdy,
    output logic [DATA_W-1:0]        wr_data,
    output logic [3:0]               wr_bl,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underflow,
    output logic                     cmd_collide
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(CWL_MAX);
    localparam int unsigned ENT_W = DATA_W + 4;
    localparam int unsigned DLY_W = 7;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [CWL_MAX-1:0] launch_sr;
    logic [CWL_MAX-1:0] launch_shift;
    logic [CWL_MAX-1:0] launch_next;
    logic [CWL_MAX-1:0] set_mask;
    logic               fire;
    logic               collide_now;

    logic [DLY_W-1:0]   d_raw;
    logic [DLY_W-1:0]   d_val;
    logic [IDX_W-1:0]   d_idx;

    assign full          = (fifo_count == CNT_W'(DEPTH));
    assign empty         = (fifo_count == '0);
    assign host_wr_ready = !full;
    assign push          = host_wr_valid && !full;
    assign pop           = fire && !empty;

    // Launch delay cwl - wr_pre, clamped to 1..CWL_MAX (bit 6 set means negative).
    always_comb begin
        d_raw = {2'b00, cwl} - {5'b00000, wr_pre};
        d_val = d_raw;
        if (d_raw[DLY_W-1] || (d_raw == '0)) begin
            d_val = DLY_W'(1);
        end else if (d_raw > DLY_W'(CWL_MAX)) begin
            d_val = DLY_W'(CWL_MAX);
        end
        d_idx = IDX_W'(d_val - DLY_W'(1));
    end

    // A new command lands in the shifted vector; fire looks at the value being
    // loaded so that a delay of 1 launches on the very next clock.
    always_comb begin
        launch_shift = launch_sr >> 1;
        set_mask     = '0;
        for (int unsigned i = 0; i < CWL_MAX; i++) begin
            set_mask[i] = (d_idx == IDX_W'(i));
        end
        collide_now = wr_cmd_issued && ((launch_shift & set_mask) != '0);
        launch_next = wr_cmd_issued ? (launch_shift | set_mask) : launch_shift;
        fire        = launch_next[0];
    end

    // Payload storage needs no reset; only pointers and count define validity.
    always_ff @(posedge CK_t) begin
        if (push) begin
            mem[wr_ptr] <= {host_bl, host_data};
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            launch_sr   <= '0;
            wr_rdy      <= 1'b0;
            wr_data     <= '0;
            wr_bl       <= '0;
            underflow   <= 1'b0;
            cmd_collide <= 1'b0;
        end else begin
            launch_sr <= launch_next;
            wr_rdy    <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                wr_data <= mem[rd_ptr][DATA_W-1:0];
                wr_bl   <= mem[rd_ptr][ENT_W-1:DATA_W];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (fire && empty) begin
                underflow <= 1'b1;
            end
            if (collide_now) begin
                cmd_collide <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_wr_data_sched.sv
// Scoreboard bench for ddr_wr_data_sched: directed commands queue expected
// launches (cycle, data, bl); a negedge monitor pops and compares them.
module tb_ddr_wr_data_sched;

    logic        CK_t = 1'b0;
    logic        reset = 1'b1;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [63:0] host_data = '0;
    logic [3:0]  host_bl = '0;
    logic        wr_cmd_issued = 1'b0;
    logic [4:0]  cwl = 5'd9;
    logic [1:0]  wr_pre = 2'd1;
    logic        wr_rdy;
    logic [63:0] wr_data;
    logic [3:0]  wr_bl;
    logic [3:0]  fifo_count;
    logic        underflow;
    logic        cmd_collide;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bl;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic [3:0]  bl;
    } exp_t;

    ent_t model_q[$];
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ddr_wr_data_sched dut (
        .CK_t          (CK_t),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_data     (host_data),
        .host_bl       (host_bl),
        .wr_cmd_issued (wr_cmd_issued),
        .cwl           (cwl),
        .wr_pre        (wr_pre),
        .wr_rdy        (wr_rdy),
        .wr_data       (wr_data),
        .wr_bl         (wr_bl),
        .fifo_count    (fifo_count),
        .underflow     (underflow),
        .cmd_collide   (cmd_collide)
    );

    always #5 CK_t = ~CK_t;

    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch monitor: every wr_rdy must match the oldest expectation in its cycle.
    always @(negedge CK_t) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_launch: got none at cycle %0d expected data %0h", exp_q[0].cyc, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (wr_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_launch: got wr_rdy at cycle %0d data %0h expected none", cyc, wr_data);
                end else begin
                    if (exp_q[0].cyc != cyc || wr_data !== exp_q[0].data || wr_bl !== exp_q[0].bl) begin
                        n_fail++;
                        $display("FAIL launch: got cycle %0d data %0h bl %0d expected cycle %0d data %0h bl %0d",
                                 cyc, wr_data, wr_bl, exp_q[0].cyc, exp_q[0].data, exp_q[0].bl);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] bl);
        host_wr_valid = 1'b1;
        host_data     = d;
        host_bl       = bl;
        tick();
        host_wr_valid = 1'b0;
        model_q.push_back('{data: d, bl: bl});
    endtask

    // Command in the current cycle; dly is the hand-computed launch distance.
    task automatic issue(input logic [4:0] c, input logic [1:0] p, input int dly, input bit expect_launch);
        ent_t e;
        wr_cmd_issued = 1'b1;
        cwl           = c;
        wr_pre        = p;
        if (expect_launch && model_q.size() > 0) begin
            e = model_q.pop_front();
            exp_q.push_back('{cyc: cyc + dly, data: e.data, bl: e.bl});
        end
        tick();
        wr_cmd_issued = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_q.delete();
        ticks(2);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        ticks(3);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_wr_rdy", 64'(wr_rdy), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_wr_bl", 64'(wr_bl), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_collide", 64'(cmd_collide), 64'd0);
        check("rst_ready", 64'(host_wr_ready), 64'd1);

        // 1: single burst, cwl=9 wr_pre=1 -> launch at T+8
        push(64'h0807060504030201, 4'd8);
        check("t1_count_pre", 64'(fifo_count), 64'd1);
        issue(5'd9, 2'd1, 8, 1'b1);
        ticks(10);
        check("t1_count_post", 64'(fifo_count), 64'd0);
        check("t1_wr_data", wr_data, 64'h0807060504030201);
        check("t1_wr_bl", 64'(wr_bl), 64'd8);

        // 2: three bursts, wr_pre=2 -> launches at T+7, T+11, T+15
        push(64'hAAAA_0000_1111_A0A0, 4'd8);
        push(64'hBBBB_2222_3333_B0B0, 4'd4);
        push(64'hCCCC_4444_5555_C0C0, 4'd8);
        issue(5'd9, 2'd2, 7, 1'b1);
        ticks(3);
        issue(5'd9, 2'd2, 7, 1'b1);
        ticks(3);
        issue(5'd9, 2'd2, 7, 1'b1);
        ticks(10);
        check("t2_count", 64'(fifo_count), 64'd0);

        // 3: fill, reject when full, free a slot, push+pop in the same clock
        for (int i = 0; i < 8; i++) push(64'h3000 + 64'(i), 4'd8);
        check("t3_full_ready", 64'(host_wr_ready), 64'd0);
        check("t3_full_count", 64'(fifo_count), 64'd8);
        host_wr_valid = 1'b1;
        host_data     = 64'hDEAD;
        host_bl       = 4'd8;
        tick();
        host_wr_valid = 1'b0;
        check("t3_no_9th", 64'(fifo_count), 64'd8);
        issue(5'd9, 2'd1, 8, 1'b1);
        ticks(6);
        check("t3_ready_before_pop", 64'(host_wr_ready), 64'd0);
        tick();
        check("t3_ready_after_pop", 64'(host_wr_ready), 64'd1);
        check("t3_count_after_pop", 64'(fifo_count), 64'd7);
        host_wr_valid = 1'b1;
        host_data     = 64'h3100;
        host_bl       = 4'd4;
        issue(5'd2, 2'd1, 1, 1'b1);
        host_wr_valid = 1'b0;
        model_q.push_back('{data: 64'h3100, bl: 4'd4});
        check("t3_push_pop_count", 64'(fifo_count), 64'd7);
        push(64'h3200, 4'd8);
        check("t3_refill_count", 64'(fifo_count), 64'd8);
        check("t3_refill_ready", 64'(host_wr_ready), 64'd0);
        tick();
        do_reset();

        // 4: command with empty FIFO -> no launch, underflow, data holds
        push(64'h4444_3333_2222_1111, 4'd4);
        issue(5'd3, 2'd1, 2, 1'b1);
        ticks(4);
        check("t4_prior_data", wr_data, 64'h4444_3333_2222_1111);
        check("t4_underflow_pre", 64'(underflow), 64'd0);
        issue(5'd10, 2'd1, 9, 1'b1);
        ticks(12);
        check("t4_underflow", 64'(underflow), 64'd1);
        check("t4_data_hold", wr_data, 64'h4444_3333_2222_1111);
        check("t4_bl_hold", 64'(wr_bl), 64'd4);

        // 5: reset two clocks after a command with 3 entries queued
        push(64'h5500, 4'd8);
        push(64'h5501, 4'd8);
        push(64'h5502, 4'd8);
        issue(5'd9, 2'd1, 8, 1'b0);
        tick();
        do_reset();
        ticks(20);
        check("t5_count", 64'(fifo_count), 64'd0);
        check("t5_ready", 64'(host_wr_ready), 64'd1);
        check("t5_wr_data", wr_data, 64'd0);
        check("t5_wr_bl", 64'(wr_bl), 64'd0);
        check("t5_underflow", 64'(underflow), 64'd0);
        check("t5_collide", 64'(cmd_collide), 64'd0);

        // 6: clamped delay of 1, then two commands mapped to the same slot
        push(64'h6666_6666_6666_6666, 4'd8);
        issue(5'd1, 2'd2, 1, 1'b1);
        ticks(3);
        check("t6_clamp_count", 64'(fifo_count), 64'd0);
        push(64'h7777_7777_7777_7777, 4'd8);
        issue(5'd12, 2'd1, 11, 1'b1);
        check("t6_no_collide_yet", 64'(cmd_collide), 64'd0);
        issue(5'd11, 2'd1, 10, 1'b0);
        check("t6_collide", 64'(cmd_collide), 64'd1);
        ticks(14);
        check("t6_collide_sticky", 64'(cmd_collide), 64'd1);
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_underflow", 64'(underflow), 64'd0);

        ticks(2);
        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
